mcs_io_bus_ctrl: RTL and testbench

Controller for the MicroBlaze MCS IO bus. It decodes each MCS IO access (addr/read/write strobes) to one of NUM_SLV peripheral slaves, sequences a single-outstanding transaction and returns IO_Ready/IO_Read_Data to the MCS. It also guards the bus with a timeout so a dead or unmapped slave cannot hang the processor. It sits between the MCS instance wrapper and the peripheral register blocks.

---
 rtl/mcs_io_pkg.sv | 25 ++
 rtl/mcs_io_timeout_cnt.sv | 31 +++
 rtl/mcs_io_bus_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mcs_io_bus_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs_io_pkg.sv
// Shared types and constants for the MCS IO bus controller.
package mcs_io_pkg;

    localparam int unsigned IO_AW  = 32;
    localparam int unsigned IO_DW  = 32;
    localparam int unsigned IO_BEW = IO_DW / 8;

    localparam logic [IO_DW-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } io_state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/mcs_io_timeout_cnt.sv
// Loadable up-counter with clear/enable and a terminal-count flag.
module mcs_io_timeout_cnt #(
    parameter int unsigned W      = 8,
    parameter logic [W-1:0] TC_VAL = '1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic         tc_c
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (ld) cnt_d = ld_val;
        else if (en) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc_c = (cnt_q == TC_VAL);

endmodule

// File: rtl/mcs_io_bus_ctrl.sv
// MCS IO bus decoder/sequencer with slave timeout.
// Optional MCS_IO_STATS_EN adds saturating transaction/error counters.
module mcs_io_bus_ctrl
    import mcs_io_pkg::*;
#(
    parameter int unsigned      NUM_SLV     = 4,
    parameter int unsigned      SEL_LSB     = 16,
    parameter int unsigned      TIMEOUT_CYC = 255,
    parameter logic [IO_DW-1:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_addr_strobe,
    input  logic                     io_read_strobe,
    input  logic                     io_write_strobe,
    input  logic [IO_AW-1:0]         io_address,
    input  logic [IO_BEW-1:0]        io_byte_enable,
    input  logic [IO_DW-1:0]         io_write_data,
    output logic [IO_DW-1:0]         io_read_data,
    output logic                     io_ready,
    output logic [NUM_SLV-1:0]       slv_sel,
    output logic                     slv_rd,
    output logic                     slv_wr,
    output logic [SEL_LSB-1:0]       slv_addr,
    output logic [IO_BEW-1:0]        slv_be,
    output logic [IO_DW-1:0]         slv_wdata,
    input  logic [NUM_SLV*IO_DW-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]       slv_ack,
`ifdef MCS_IO_STATS_EN
    output logic [15:0]              stat_txn_cnt,
    output logic [15:0]              stat_err_cnt,
`endif
    output logic                     err_irq,
    output logic [IO_AW-1:0]         err_addr
);

    // Decode field is wide enough to hold NUM_SLV itself so out-of-range indices are visible.
    localparam int unsigned DEC_W = clog2(NUM_SLV + 1);
    localparam int unsigned IDX_W = (NUM_SLV > 1) ? clog2(NUM_SLV) : 1;
    localparam int unsigned CNT_W = clog2(TIMEOUT_CYC + 1);

    io_state_e           state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                rd_q, rd_d;
    logic [IO_AW-1:0]    addr_q, addr_d;
    logic [IO_BEW-1:0]   be_q, be_d;
    logic [IO_DW-1:0]    wdata_q, wdata_d;
    logic [NUM_SLV-1:0]  slv_sel_q, slv_sel_d;
    logic                slv_rd_q, slv_rd_d;
    logic                slv_wr_q, slv_wr_d;
    logic                io_ready_q, io_ready_d;
    logic [IO_DW-1:0]    io_read_data_q, io_read_data_d;
    logic                err_irq_q, err_irq_d;
    logic [IO_AW-1:0]    err_addr_q, err_addr_d;

    logic [DEC_W-1:0]    dec_idx_c;
    logic                dec_ok_c;
    logic                ack_c;
    logic [IO_DW-1:0]    sel_rdata_c;
    logic                tmo_c;

    assign dec_idx_c   = io_address[SEL_LSB +: DEC_W];
    assign dec_ok_c    = (32'(dec_idx_c) < NUM_SLV);
    assign ack_c       = slv_ack[idx_q];
    assign sel_rdata_c = slv_rdata[IO_DW*idx_q +: IO_DW];

    mcs_io_timeout_cnt #(
        .W      (CNT_W),
        .TC_VAL (CNT_W'(TIMEOUT_CYC - 1))
    ) u_tmo (
        .clock  (clock),
        .reset  (reset),
        .clr    (state_q != ST_WAIT),
        .en     (state_q == ST_WAIT),
        .ld     (1'b0),
        .ld_val ('0),
        .tc_c   (tmo_c)
    );

    // Next-state and registered-output logic; RESP outputs are set on entry to RESP.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        rd_d           = rd_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        slv_sel_d      = slv_sel_q;
        slv_rd_d       = 1'b0;
        slv_wr_d       = 1'b0;
        io_ready_d     = 1'b0;
        io_read_data_d = '0;
        err_irq_d      = 1'b0;
        err_addr_d     = err_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (io_addr_strobe && (io_read_strobe || io_write_strobe)) begin
                    rd_d    = io_read_strobe;
                    addr_d  = io_address;
                    be_d    = io_byte_enable;
                    wdata_d = io_write_data;
                    if (dec_ok_c) begin
                        idx_d     = IDX_W'(dec_idx_c);
                        slv_sel_d = NUM_SLV'(1) << dec_idx_c;
                        slv_rd_d  = io_read_strobe;
                        slv_wr_d  = !io_read_strobe;
                        state_d   = ST_REQ;
                    end else begin
                        io_ready_d     = 1'b1;
                        io_read_data_d = io_read_strobe ? ERR_DATA : '0;
                        err_irq_d      = 1'b1;
                        err_addr_d     = io_address;
                        state_d        = ST_RESP;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                if (ack_c) begin
                    io_ready_d     = 1'b1;
                    io_read_data_d = rd_q ? sel_rdata_c : '0;
                    state_d        = ST_RESP;
                end else if (state_q == ST_REQ) begin
                    state_d = ST_WAIT;
                end else if (tmo_c) begin
                    io_ready_d     = 1'b1;
                    io_read_data_d = rd_q ? ERR_DATA : '0;
                    err_irq_d      = 1'b1;
                    err_addr_d     = addr_q;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                slv_sel_d = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            rd_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            slv_sel_q      <= '0;
            slv_rd_q       <= 1'b0;
            slv_wr_q       <= 1'b0;
            io_ready_q     <= 1'b0;
            io_read_data_q <= '0;
            err_irq_q      <= 1'b0;
            err_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            rd_q           <= rd_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            slv_sel_q      <= slv_sel_d;
            slv_rd_q       <= slv_rd_d;
            slv_wr_q       <= slv_wr_d;
            io_ready_q     <= io_ready_d;
            io_read_data_q <= io_read_data_d;
            err_irq_q      <= err_irq_d;
            err_addr_q     <= err_addr_d;
        end
    end

    assign io_ready     = io_ready_q;
    assign io_read_data = io_read_data_q;
    assign slv_sel      = slv_sel_q;
    assign slv_rd       = slv_rd_q;
    assign slv_wr       = slv_wr_q;
    assign slv_addr     = addr_q[SEL_LSB-1:0];
    assign slv_be       = be_q;
    assign slv_wdata    = wdata_q;
    assign err_irq      = err_irq_q;
    assign err_addr     = err_addr_q;

`ifdef MCS_IO_STATS_EN
    logic [15:0] txn_cnt_q, txn_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating counters driven by the registered response pulses.
    always_comb begin
        txn_cnt_d = txn_cnt_q;
        err_cnt_d = err_cnt_q;
        if (io_ready_q && (txn_cnt_q != 16'hFFFF)) txn_cnt_d = txn_cnt_q + 16'd1;
        if (err_irq_q  && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txn_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_txn_cnt = txn_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mcs_io_bus_ctrl.sv
// Randomized self-checking bench for mcs_io_bus_ctrl against a transaction-level model.
module tb_mcs_io_bus_ctrl;

    localparam int unsigned NS = 4;
    localparam int unsigned SL = 16;
    localparam int unsigned TC = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io_addr_strobe = 1'b0;
    logic          io_read_strobe = 1'b0;
    logic          io_write_strobe = 1'b0;
    logic [31:0]   io_address = '0;
    logic [3:0]    io_byte_enable = '0;
    logic [31:0]   io_write_data = '0;
    logic [31:0]   io_read_data;
    logic          io_ready;
    logic [NS-1:0] slv_sel;
    logic          slv_rd;
    logic          slv_wr;
    logic [SL-1:0] slv_addr;
    logic [3:0]    slv_be;
    logic [31:0]   slv_wdata;
    logic [NS*32-1:0] slv_rdata = '0;
    logic [NS-1:0] slv_ack = '0;
    logic          err_irq;
    logic [31:0]   err_addr;
`ifdef MCS_IO_STATS_EN
    logic [15:0]   stat_txn_cnt;
    logic [15:0]   stat_err_cnt;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_err_addr = '0;
    int          m_txn = 0;
    int          m_err = 0;

    always #5 clock = ~clock;

    mcs_io_bus_ctrl #(
        .NUM_SLV     (NS),
        .SEL_LSB     (SL),
        .TIMEOUT_CYC (TC),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_address      (io_address),
        .io_byte_enable  (io_byte_enable),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .slv_sel         (slv_sel),
        .slv_rd          (slv_rd),
        .slv_wr          (slv_wr),
        .slv_addr        (slv_addr),
        .slv_be          (slv_be),
        .slv_wdata       (slv_wdata),
        .slv_rdata       (slv_rdata),
        .slv_ack         (slv_ack),
`ifdef MCS_IO_STATS_EN
        .stat_txn_cnt    (stat_txn_cnt),
        .stat_err_cnt    (stat_err_cnt),
`endif
        .err_irq         (err_irq),
        .err_addr        (err_addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_ready"}, 32'(io_ready), 32'd0);
        check_eq({tag, "_rdata"}, io_read_data, 32'd0);
        check_eq({tag, "_sel"}, 32'(slv_sel), 32'd0);
        check_eq({tag, "_rdwr"}, 32'({slv_rd, slv_wr}), 32'd0);
        check_eq({tag, "_saddr"}, 32'(slv_addr), 32'd0);
        check_eq({tag, "_sbe"}, 32'(slv_be), 32'd0);
        check_eq({tag, "_swdata"}, slv_wdata, 32'd0);
        check_eq({tag, "_irq"}, 32'(err_irq), 32'd0);
        check_eq({tag, "_eaddr"}, err_addr, 32'd0);
    endtask

    task automatic clear_inputs();
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        slv_ack         = '0;
    endtask

    // One MCS access. ack_k: ack this many cycles after the slave strobe (<0 = never).
    // noise: spurious acks from other slaves and ignored strobes. rst_at: cycle to reset in (<0 = none).
    task automatic run_txn(input bit rd, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [31:0] sel_rd,
                           input int ack_k, input bit noise, input int rst_at);
        int           idx;
        bit           dec_err, tmo_err, is_err;
        int           exp_lat, n_rdy, strobes, irqs;
        logic [127:0] rv;
        logic [3:0]   sel_exp;
        logic [31:0]  exp_data;

        idx     = int'(addr[SL +: 3]);
        dec_err = (idx >= int'(NS));
        tmo_err = !dec_err && (ack_k < 0 || ack_k > int'(TC));
        is_err  = dec_err || tmo_err;
        exp_lat = dec_err ? 1 : (tmo_err ? 2 + int'(TC) : 2 + ack_k);
        sel_exp = dec_err ? 4'b0000 : 4'(1 << idx);
        rv      = {$urandom, $urandom, $urandom, $urandom};
        if (!dec_err) rv[32*idx +: 32] = sel_rd;
        exp_data = !rd ? 32'd0 : (is_err ? 32'hDEAD_BEEF : sel_rd);
        n_rdy = -1; strobes = 0; irqs = 0;

        @(negedge clock);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = !rd;
        io_address      = addr;
        io_byte_enable  = be;
        io_write_data   = wdata;
        slv_rdata       = rv;

        for (int n = 1; n <= int'(TC) + 6; n++) begin
            @(negedge clock);
            if (n == 1) begin
                check_eq("t1_sel", 32'(slv_sel), 32'(sel_exp));
                check_eq("t1_rd", 32'(slv_rd), 32'(rd && !dec_err));
                check_eq("t1_wr", 32'(slv_wr), 32'(!rd && !dec_err));
            end
            strobes += int'(slv_rd) + int'(slv_wr);
            irqs    += int'(err_irq);
            if (io_ready) begin
                n_rdy = n;
                clear_inputs();
                break;
            end
            io_addr_strobe = noise && (n >= 2) && ($urandom_range(0, 1) == 1);
            io_read_strobe = 1'b1;
            if (io_addr_strobe) io_address = $urandom;
            slv_ack = '0;
            if (!dec_err && n == 1 + ack_k) slv_ack = sel_exp;
            if (noise) slv_ack = slv_ack | (4'($urandom) & ~sel_exp) | ((idx != 0) ? 4'b0001 : 4'b0000);
            if (rst_at == n) begin
                #2 reset = 1'b1;
                #1 check_reset_outs("async_rst");
                m_err_addr = '0; m_txn = 0; m_err = 0;
                clear_inputs();
                @(negedge clock);
                @(negedge clock);
                reset = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    check_eq("post_rst_ready", 32'(io_ready), 32'd0);
                end
                return;
            end
        end

        if (n_rdy < 0) begin
            check_eq("ready_seen", 32'd0, 32'd1);
        end else begin
            m_txn++;
            if (is_err) begin
                m_err++;
                m_err_addr = addr;
            end
            check_eq("latency", 32'(n_rdy), 32'(exp_lat));
            check_eq("rdata", io_read_data, exp_data);
            check_eq("irq", 32'(err_irq), 32'(is_err));
            check_eq("eaddr", err_addr, m_err_addr);
            check_eq("slv_strobes", 32'(strobes), dec_err ? 32'd0 : 32'd1);
            check_eq("irq_pulses", 32'(irqs), 32'(is_err));
            if (!dec_err) begin
                check_eq("hold_sel", 32'(slv_sel), 32'(sel_exp));
                check_eq("hold_addr", 32'(slv_addr), 32'(addr[SL-1:0]));
                check_eq("hold_be", 32'(slv_be), 32'(be));
                check_eq("hold_wdata", slv_wdata, wdata);
            end
            @(negedge clock);
            check_eq("after_ready", 32'(io_ready), 32'd0);
            check_eq("after_rdata", io_read_data, 32'd0);
            check_eq("after_sel", 32'(slv_sel), 32'd0);
            check_eq("after_irq", 32'(err_irq), 32'd0);
        end
    endtask

    initial begin
        #2 reset = 1'b1;
        #1 check_reset_outs("init_rst");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        run_txn(1'b1, 32'hC002_0010, 4'hF, 32'h0, 32'h1234_5678, 0, 1'b0, -1);
        run_txn(1'b0, 32'h0001_0024, 4'b0011, 32'hA5A5_0000, 32'h0, 3, 1'b0, -1);
        run_txn(1'b1, 32'h0003_0100, 4'hF, 32'h0, 32'h5555_AAAA, -1, 1'b0, -1);
        run_txn(1'b1, 32'h0005_0000, 4'hF, 32'h0, 32'h0, 0, 1'b0, -1);
        run_txn(1'b0, 32'h0007_0004, 4'hF, 32'h1111_2222, 32'h0, 0, 1'b0, -1);
        run_txn(1'b1, 32'h0000_00F0, 4'hF, 32'h0, 32'hCAFE_F00D, int'(TC), 1'b0, -1);
        run_txn(1'b1, 32'h0002_0008, 4'hF, 32'h0, 32'h0, -1, 1'b0, 4);
        run_txn(1'b1, 32'h0001_0040, 4'hF, 32'h0, 32'h0BAD_F00D, 2, 1'b1, -1);

        // Strobe without read or write must be ignored.
        @(negedge clock);
        io_addr_strobe = 1'b1;
        io_address     = 32'h0000_0000;
        @(negedge clock);
        clear_inputs();
        for (int j = 0; j < 3; j++) begin
            check_eq("nodir_idle", 32'({io_ready, slv_rd, slv_wr, slv_sel}), 32'd0);
            @(negedge clock);
        end

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int          k;
            a = $urandom;
            a[18:16] = 3'($urandom_range(0, 7));
            k = $urandom_range(0, TC + 3);
            run_txn(1'($urandom), a, 4'($urandom), $urandom, $urandom,
                    (k > int'(TC)) ? -1 : k, 1'($urandom), -1);
        end

`ifdef MCS_IO_STATS_EN
        check_eq("stat_txn", 32'(stat_txn_cnt), 32'(m_txn));
        check_eq("stat_err", 32'(stat_err_cnt), 32'(m_err));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
